iq_block_ctrl: RTL and testbench



---
 rtl/iq_ctrl_pkg.sv | 16 +
 rtl/iq_block_ctrl_if.sv | 32 +++
 rtl/iq_stall_watchdog.sv | 32 +++
 rtl/iq_block_ctrl.sv | 138 +++++++++++++
 tb/tb_iq_block_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/iq_ctrl_pkg.sv
// Shared definitions for the IQ block sequencer: FSM state codes, the
// fixed byte-per-sample protocol constant and the default counter width.
package iq_ctrl_pkg;

  localparam int COUNT_W_DEF      = 16;
  // I lo, I hi, Q lo, Q hi
  localparam int BYTES_PER_SAMPLE = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/iq_block_ctrl_if.sv
// Host, byte FIFO and IQ-stage signals of the IQ block sequencer.
// master: the surrounding system (host, FIFO, IQ stage); slave: the sequencer.
interface iq_block_ctrl_if
  import iq_ctrl_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF
) ();

  logic               start;
  logic [COUNT_W-1:0] num_samples;
  logic               abort;
  logic               src_empty;
  logic               src_rd_en;
  logic               iq_in_empty;
  logic               iq_rd_en;
  logic               iq_wr_en;
  logic               busy;
  logic               done;
  logic [COUNT_W-1:0] samples_done;
  logic               error;

  modport master (
    output start, num_samples, abort, src_empty, iq_rd_en, iq_wr_en,
    input  src_rd_en, iq_in_empty, busy, done, samples_done, error
  );

  modport slave (
    input  start, num_samples, abort, src_empty, iq_rd_en, iq_wr_en,
    output src_rd_en, iq_in_empty, busy, done, samples_done, error
  );

endinterface

// File: rtl/iq_stall_watchdog.sv
// Stall watchdog: counts consecutive cycles with no byte grant and no sample
// write while a block is active; flags expiry once the limit is reached.
module iq_stall_watchdog
  import iq_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  input  logic activity,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] stall_cnt;

  assign expired = (stall_cnt == CNT_W'(TIMEOUT_CYCLES));

  // Idle-cycle counter; saturates at the limit so expiry stays asserted.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!active || activity) begin
      stall_cnt <= '0;
    end else if (!expired) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/iq_block_ctrl.sv
// IQ block sequencer: gates the byte FIFO into the IQ deinterleave stage so
// exactly num_samples I/Q pairs are processed per start command, with abort
// at a clean sample boundary.
// Optional feature macro: IQ_TIMEOUT_EN (stall watchdog, sticky error).
module iq_block_ctrl
  import iq_ctrl_pkg::*;
#(
  parameter int COUNT_W        = COUNT_W_DEF,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic            clock,
  input logic            reset,
  iq_block_ctrl_if.slave bus
);

  localparam int BG_W = COUNT_W + 2;

  state_t             state;
  logic [COUNT_W-1:0] target;
  logic [BG_W-1:0]    bytes_granted;
  logic [COUNT_W-1:0] samples_done_q;
  logic               abort_req;
  logic               done_q;

  logic [BG_W-1:0]    target_bytes;
  logic [BG_W-1:0]    emitted_bytes;
  logic               sample_aligned;
  logic               abort_stop;
  logic               allow;
  logic               busy_int;
  logic               grant;
  logic               wr_evt;
  logic               timeout;

  assign target_bytes   = BG_W'(target) * BG_W'(BYTES_PER_SAMPLE);
  assign emitted_bytes  = BG_W'(samples_done_q) * BG_W'(BYTES_PER_SAMPLE);
  assign sample_aligned = ((bytes_granted % BG_W'(BYTES_PER_SAMPLE)) == '0);
  assign abort_stop     = abort_req && sample_aligned;
  assign allow          = (state == ST_RUN) && !abort_stop && (bytes_granted < target_bytes);
  assign busy_int       = (state == ST_RUN) || (state == ST_DRAIN);

  // The IQ stage only ever sees bytes we are willing to hand over this block.
  assign grant           = bus.iq_rd_en & allow & ~bus.src_empty;
  assign wr_evt          = bus.iq_wr_en & busy_int;
  assign bus.src_rd_en   = grant;
  assign bus.iq_in_empty = bus.src_empty | ~allow;
  assign bus.busy        = busy_int;
  assign bus.done        = done_q;
  assign bus.samples_done = samples_done_q;

`ifdef IQ_TIMEOUT_EN
  logic error_q;

  iq_stall_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .active  (busy_int),
    .activity(grant | wr_evt),
    .expired (timeout)
  );

  // Sticky stall error; a new accepted start clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      error_q <= 1'b0;
    end else if ((state == ST_IDLE) && bus.start) begin
      error_q <= 1'b0;
    end else if (timeout && busy_int) begin
      error_q <= 1'b1;
    end
  end

  assign bus.error = error_q;
`else
  // Without the watchdog a stalled block simply waits forever.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout   = 1'b0;
  assign bus.error = 1'b0;
`endif

  // Block FSM with its byte/sample counters; done is a registered pulse
  // issued the cycle after the DONE state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      target         <= '0;
      bytes_granted  <= '0;
      samples_done_q <= '0;
      abort_req      <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      done_q <= (state == ST_DONE);
      if (grant) begin
        bytes_granted <= bytes_granted + 1'b1;
      end
      if (wr_evt) begin
        samples_done_q <= samples_done_q + 1'b1;
      end
      if ((state == ST_RUN) && bus.abort) begin
        abort_req <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            target         <= bus.num_samples;
            bytes_granted  <= '0;
            samples_done_q <= '0;
            abort_req      <= 1'b0;
            state          <= (bus.num_samples == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (timeout) begin
            state <= ST_DONE;
          end else if ((bytes_granted == target_bytes) || abort_stop) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The IQ stage may sit on its last sample for as long as its
          // output is full; wait until every granted byte has been emitted.
          if (timeout) begin
            state <= ST_DONE;
          end else if (emitted_bytes == bytes_granted) begin
            state <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iq_block_ctrl.sv
// Self-checking bench for iq_block_ctrl: emulates the byte FIFO and the
// 4-bytes-in / 1-sample-out IQ stage, and predicts each block's totals from
// the command, abort point and stall point.
module tb_iq_block_ctrl;

`ifdef IQ_TIMEOUT_EN
  localparam int TMO  = 16;
  localparam int HOLD = 10;
`else
  localparam int TMO  = 1024;
  localparam int HOLD = 50;
`endif

  logic clock = 1'b0;
  logic reset;

  iq_block_ctrl_if #(.COUNT_W(16)) bus ();

  iq_block_ctrl #(
    .COUNT_W       (16),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // IQ stage / FIFO emulation state and per-block observations
  int have, hold_len, hold_left, mode, stuck_after;
  bit hold_last, busy_prev;
  int reads, writes, dones, rd_empty, busy_cycles;
  int cyc, last_wr_cyc, done_cyc, start_cyc;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, observe 1ns later, update the stage
  // emulation on the following posedge.
  task automatic cycle(input bit st, input bit ab, input int n);
    bit rd, wr;
    @(negedge clock);
    bus.start       = st;
    bus.abort       = ab;
    bus.num_samples = 16'(n);
    case (mode)
      0:       bus.src_empty = 1'b0;
      1:       bus.src_empty = cyc[0];
      2:       bus.src_empty = 1'($urandom_range(0, 1));
      default: bus.src_empty = 1'b1;
    endcase
    if (stuck_after >= 0 && reads >= stuck_after) bus.src_empty = 1'b1;
    bus.iq_rd_en = (have < 4);
    wr = (have == 4 && hold_left == 0);
    bus.iq_wr_en = wr;
    #1;
    rd = bus.src_rd_en;
    if (rd) begin
      reads++;
      if (bus.src_empty) rd_empty++;
    end
    if (wr) begin
      writes++;
      last_wr_cyc = cyc;
    end
    if (bus.done) begin
      dones++;
      done_cyc = cyc;
    end
    if (bus.busy) busy_cycles++;
    busy_prev = bus.busy;
    @(posedge clock);
    if (wr) begin
      have = 0;
    end else if (rd) begin
      have++;
      if (have == 4) hold_left = (hold_last && (writes + 1 != n)) ? 0 : hold_len;
    end else if (have == 4 && hold_left > 0) begin
      hold_left--;
    end
    cyc++;
  endtask

  task automatic run_block(input int n, input int abort_at, input int m, input int hl,
                           input bit hlast, input bit start_in_drain, input int stuck,
                           input bit expect_timeout, input string tag);
    int exp_reads, abort_reads, budget, r;
    bit aborted;
    mode = m; hold_len = hl; hold_last = hlast; stuck_after = stuck;
    have = 0; hold_left = 0; reads = 0; writes = 0; dones = 0; rd_empty = 0;
    busy_cycles = 0; last_wr_cyc = -1; done_cyc = -1; busy_prev = 1'b0;
    abort_reads = -1; aborted = 1'b0;
    start_cyc = cyc;
    cycle(1'b1, 1'b0, n);
    budget = 0;
    while (dones == 0 && budget < 3000) begin
      bit ab, st;
      ab = (abort_at >= 0) && !aborted && (reads == abort_at);
      st = start_in_drain && busy_prev && (budget % 7 == 0);
      cycle(st, ab, n);
      if (ab) begin
        aborted = 1'b1;
        abort_reads = reads;
      end
      budget++;
    end
    chk({tag, "_done_within_budget"}, budget < 3000, 1);
    repeat (3) cycle(1'b0, 1'b0, n);
    #2;

    // Expected totals: full block, or the abort point rounded up to a whole
    // sample, or wherever the source dried up when the watchdog fires.
    if (expect_timeout) begin
      exp_reads = stuck;
    end else begin
      exp_reads = 4 * n;
      if (abort_reads >= 0) begin
        r = ((abort_reads + 3) / 4) * 4;
        if (r < exp_reads) exp_reads = r;
      end
    end
    chk({tag, "_reads"}, reads, exp_reads);
    chk({tag, "_writes"}, writes, exp_reads / 4);
    chk({tag, "_samples_done"}, bus.samples_done, exp_reads / 4);
    chk({tag, "_done_pulses"}, dones, 1);
    chk({tag, "_rd_while_empty"}, rd_empty, 0);
    chk({tag, "_idle_in_empty"}, bus.iq_in_empty, 1);
    chk({tag, "_idle_busy"}, bus.busy, 0);
    chk({tag, "_error"}, bus.error, expect_timeout);
    if (n == 0) begin
      chk({tag, "_done_latency"}, done_cyc - start_cyc, 2);
      chk({tag, "_busy_cycles"}, busy_cycles, 0);
    end else if (!expect_timeout) begin
      chk({tag, "_done_after_last_wr"},
          (done_cyc > last_wr_cyc) && (done_cyc - last_wr_cyc <= 4), 1);
    end
  endtask

  initial begin
    int n, ab_at;
    mode = 0; stuck_after = -1; have = 0; hold_len = 0; hold_left = 0;
    hold_last = 1'b0; cyc = 0; reads = 0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.num_samples = '0;
    bus.src_empty = 1'b0; bus.iq_rd_en = 1'b1; bus.iq_wr_en = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_src_rd_en", bus.src_rd_en, 0);
    chk("rst_iq_in_empty", bus.iq_in_empty, 1);
    chk("rst_samples_done", bus.samples_done, 0);
    @(negedge clock);
    reset = 1'b0;

    run_block(3, -1, 0, 0, 1'b0, 1'b0, -1, 1'b0, "n3");
    run_block(0, -1, 0, 0, 1'b0, 1'b0, -1, 1'b0, "n0");
    run_block(4, -1, 1, 0, 1'b0, 1'b0, -1, 1'b0, "toggle");
    run_block(10, 6, 0, 0, 1'b0, 1'b0, -1, 1'b0, "abort6");
    run_block(2, 7, 0, 0, 1'b0, 1'b0, -1, 1'b0, "abort_final");
    run_block(2, -1, 0, HOLD, 1'b1, 1'b1, -1, 1'b0, "hold");
    chk("hold_busy_span", busy_cycles >= HOLD, 1);

    for (int i = 0; i < 4; i++) begin
      n = $urandom_range(1, 6);
      ab_at = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 4 * n)) : -1;
      run_block(n, ab_at, 2, $urandom_range(0, 3), 1'b0, 1'b0, -1, 1'b0, "rand");
    end

`ifdef IQ_TIMEOUT_EN
    run_block(3, -1, 0, 0, 1'b0, 1'b0, 6, 1'b1, "timeout");
    run_block(1, -1, 0, 0, 1'b0, 1'b0, -1, 1'b0, "after_timeout");
`endif

    // Reset in the middle of a block returns the sequencer to idle at once.
    mode = 0; stuck_after = -1; hold_len = 0; have = 0; hold_left = 0; reads = 0;
    cycle(1'b1, 1'b0, 5);
    repeat (8) cycle(1'b0, 1'b0, 5);
    chk("mid_busy_before_reset", bus.busy, 1);
    reset = 1'b1;
    cycle(1'b0, 1'b0, 5);
    #1;
    chk("mid_reset_busy", bus.busy, 0);
    chk("mid_reset_samples", bus.samples_done, 0);
    chk("mid_reset_in_empty", bus.iq_in_empty, 1);
    chk("mid_reset_rd_en", bus.src_rd_en, 0);
    @(negedge clock);
    reset = 1'b0;
    run_block(1, -1, 0, 0, 1'b0, 1'b0, -1, 1'b0, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
